// File: rtl/math_adder_carry_save.sv
// Bit-level full-adder cell: three one-bit inputs compressed to sum and carry.
module math_adder_carry_save (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic ow_sum,
    output logic ow_carry
);

    assign ow_sum   = i_a ^ i_b ^ i_c;
    assign ow_carry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/math_adder_half.sv
// Bit-level half-adder cell: two one-bit inputs compressed to sum and carry.
module math_adder_half (
    input  logic i_a,
    input  logic i_b,
    output logic ow_sum,
    output logic ow_carry
);

    assign ow_sum   = i_a ^ i_b;
    assign ow_carry = i_a & i_b;

endmodule

// File: rtl/math_adder_csa_array_reg.sv
// Registered N-bit carry-save (3:2 or 2:2) compressor array with a resolved
// binary total built from a ripple chain of full-adder cells.
module math_adder_csa_array_reg #(
    parameter int unsigned N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    input  logic         i_ha_mode,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [N-1:0] i_c,
    output logic         o_valid,
    output logic [N-1:0] o_sum,
    output logic [N-1:0] o_carry,
    output logic [N+1:0] o_total
);

    localparam int unsigned RW = N + 1;

    logic [N-1:0] fa_sum;
    logic [N-1:0] fa_carry;
    logic [N-1:0] ha_sum;
    logic [N-1:0] ha_carry;
    logic [N-1:0] cmp_sum;
    logic [N-1:0] cmp_carry;

    // Both cells exist at every bit; the mode only steers the mux below.
    for (genvar k = 0; k < int'(N); k++) begin : g_bit
        math_adder_carry_save u_fa (
            .i_a     (i_a[k]),
            .i_b     (i_b[k]),
            .i_c     (i_c[k]),
            .ow_sum  (fa_sum[k]),
            .ow_carry(fa_carry[k])
        );

        math_adder_half u_ha (
            .i_a     (i_a[k]),
            .i_b     (i_b[k]),
            .ow_sum  (ha_sum[k]),
            .ow_carry(ha_carry[k])
        );
    end

    always_comb begin
        cmp_sum   = fa_sum;
        cmp_carry = fa_carry;
        if (i_ha_mode) begin
            cmp_sum   = ha_sum;
            cmp_carry = ha_carry;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_sum   <= '0;
            o_carry <= '0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_sum   <= cmp_sum;
                o_carry <= cmp_carry;
            end
        end
    end

    // Resolver: carry vector carries weight 2^(k+1), so it enters shifted by one.
    logic [RW-1:0] res_a;
    logic [RW-1:0] res_b;
    logic [RW-1:0] res_sum;

    assign res_a = {1'b0, o_sum};
    assign res_b = {o_carry, 1'b0};

    for (genvar k = 0; k < int'(RW); k++) begin : g_res
        logic cin;
        logic cout;

        if (k == 0) begin : g_first
            assign cin = 1'b0;
        end else begin : g_next
            assign cin = g_res[k-1].cout;
        end

        math_adder_carry_save u_rfa (
            .i_a     (res_a[k]),
            .i_b     (res_b[k]),
            .i_c     (cin),
            .ow_sum  (res_sum[k]),
            .ow_carry(cout)
        );
    end

    assign o_total = {g_res[RW-1].cout, res_sum};

endmodule

// File: tb/tb_math_adder_csa_array_reg.sv
// Self-checking bench for math_adder_csa_array_reg: directed vector table,
// reset/hold sequences and a randomized run against an arithmetic model.
module tb_math_adder_csa_array_reg;

    localparam int unsigned N = 8;
    localparam int unsigned NV = 9;
    localparam int unsigned NRAND = 10000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0;
    logic         ha_mode = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [N-1:0] c = '0;
    logic         o_valid;
    logic [N-1:0] o_sum;
    logic [N-1:0] o_carry;
    logic [N+1:0] o_total;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic         ha;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] c;
        logic [N-1:0] sum;
        logic [N-1:0] carry;
        logic [N+1:0] total;
    } vec_t;

    vec_t vecs[NV];

    math_adder_csa_array_reg #(.N(N)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (valid),
        .i_ha_mode(ha_mode),
        .i_a      (a),
        .i_b      (b),
        .i_c      (c),
        .o_valid  (o_valid),
        .o_sum    (o_sum),
        .o_carry  (o_carry),
        .o_total  (o_total)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ha, input logic [N-1:0] va,
                         input logic [N-1:0] vb, input logic [N-1:0] vc);
        valid   = v;
        ha_mode = ha;
        a       = va;
        b       = vb;
        c       = vc;
    endtask

    task automatic check_all(input string tag, input logic v, input logic [N-1:0] s,
                             input logic [N-1:0] cy, input logic [N+1:0] t);
        check({tag, ".valid"}, 32'(o_valid), 32'(v));
        check({tag, ".sum"},   32'(o_sum),   32'(s));
        check({tag, ".carry"}, 32'(o_carry), 32'(cy));
        check({tag, ".total"}, 32'(o_total), 32'(t));
    endtask

    initial begin
        logic [N-1:0] ra, rb, rc, exp_sum, held_sum;
        logic         rha, rv;
        int unsigned  exp_tot, held_tot;

        vecs[0] = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 10'h2FD};
        vecs[1] = '{1'b0, 8'hA5, 8'h5A, 8'h0F, 8'hF0, 8'h0F, 10'h10E};
        vecs[2] = '{1'b1, 8'h3C, 8'h0F, 8'hFF, 8'h33, 8'h0C, 10'h04B};
        vecs[3] = '{1'b1, 8'h3C, 8'h0F, 8'h00, 8'h33, 8'h0C, 10'h04B};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 10'h000};
        vecs[5] = '{1'b1, 8'hFF, 8'hFF, 8'hAA, 8'h00, 8'hFF, 10'h1FE};
        vecs[6] = '{1'b0, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 10'h001};
        vecs[7] = '{1'b0, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 10'h180};
        vecs[8] = '{1'b0, 8'hF0, 8'h0F, 8'h00, 8'hFF, 8'h00, 10'h0FF};

        // Reset held with live stimulus and a running clock.
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            step();
        end
        check_all("reset", 1'b0, 8'h00, 8'h00, 10'h000);

        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;
        step();
        check_all("post_reset_idle", 1'b0, 8'h00, 8'h00, 10'h000);

        for (int i = 0; i < int'(NV); i++) begin
            drive(1'b1, vecs[i].ha, vecs[i].a, vecs[i].b, vecs[i].c);
            step();
            check_all($sformatf("vec%0d", i), 1'b1, vecs[i].sum, vecs[i].carry, vecs[i].total);
        end

        // Hold with i_valid low, then asynchronous reset between edges.
        drive(1'b1, 1'b0, 8'hA5, 8'h5A, 8'h0F);
        step();
        check_all("hold_load", 1'b1, 8'hF0, 8'h0F, 10'h10E);
        drive(1'b0, 1'b1, 8'h12, 8'h34, 8'h56);
        step();
        check_all("hold", 1'b0, 8'hF0, 8'h0F, 10'h10E);
        #2 rst_n = 1'b0;
        #1;
        check_all("async_reset", 1'b0, 8'h00, 8'h00, 10'h000);
        #1 rst_n = 1'b1;
        step();
        check_all("after_async_reset", 1'b0, 8'h00, 8'h00, 10'h000);

        // Randomized run; model holds the last captured result on idle cycles.
        held_sum = '0;
        held_tot = 0;
        for (int i = 0; i < int'(NRAND); i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rc  = 8'($urandom);
            rha = 1'($urandom);
            rv  = ($urandom_range(0, 7) != 0);
            drive(rv, rha, ra, rb, rc);
            step();
            if (rv) begin
                exp_tot  = int'(ra) + int'(rb) + (rha ? 0 : int'(rc));
                exp_sum  = rha ? (ra ^ rb) : (ra ^ rb ^ rc);
                held_sum = exp_sum;
                held_tot = exp_tot;
            end
            check("rand.valid", 32'(o_valid), 32'(rv));
            check("rand.total", 32'(o_total), held_tot);
            check("rand.csa", 32'(o_sum) + 32'(o_carry) * 2, held_tot);
            check("rand.sum", 32'(o_sum), 32'(held_sum));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
